// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring shift-and-subtract divider, signed/unsigned, fixed latency
module seq_divider #(
  parameter int DIV_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signedOp,
  input  logic [DIV_SIZE-1:0] dIn0,
  input  logic [DIV_SIZE-1:0] dIn1,
  output logic                busy,
  output logic                done,
  output logic                divByZero,
  output logic [DIV_SIZE-1:0] quotient,
  output logic [DIV_SIZE-1:0] remainder
);

  localparam int CW = $clog2(DIV_SIZE);
  localparam logic [CW-1:0]       LAST    = CW'(DIV_SIZE - 1);
  localparam logic [DIV_SIZE-1:0] MIN_VAL = {1'b1, {(DIV_SIZE-1){1'b0}}};
  localparam logic [DIV_SIZE-1:0] ONE     = {{(DIV_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_count;
  logic [DIV_SIZE-1:0] r_rem;
  logic [DIV_SIZE-1:0] r_dvd;
  logic [DIV_SIZE-1:0] r_dvs;
  logic [DIV_SIZE-1:0] r_dvd_orig;
  logic                r_neg_d;
  logic                r_neg_v;
  logic                r_dbz;
  logic [DIV_SIZE-1:0] r_quotient;
  logic [DIV_SIZE-1:0] r_remainder;

  logic [DIV_SIZE-1:0] w_abs0;
  logic [DIV_SIZE-1:0] w_abs1;
  logic [DIV_SIZE:0]   w_shift;
  logic [DIV_SIZE:0]   w_trial;
  logic                w_ovf;
  logic [DIV_SIZE-1:0] w_q_fix;
  logic [DIV_SIZE-1:0] w_r_fix;

  assign w_abs0  = (signedOp && dIn0[DIV_SIZE-1]) ? -dIn0 : dIn0;
  assign w_abs1  = (signedOp && dIn1[DIV_SIZE-1]) ? -dIn1 : dIn1;

  // Trial subtraction is one bit wider so its MSB acts as the borrow/sign.
  assign w_shift = {r_rem, r_dvd[DIV_SIZE-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  // Magnitude 1 with a negative sign flag means the divisor was -1.
  assign w_ovf   = r_neg_v && (r_dvs == ONE) && (r_dvd_orig == MIN_VAL);
  assign w_q_fix = (r_neg_d ^ r_neg_v) ? -r_dvd : r_dvd;
  assign w_r_fix = r_neg_d ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_count == LAST) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_dvd_orig  <= '0;
      r_neg_d     <= 1'b0;
      r_neg_v     <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd      <= w_abs0;
            r_dvs      <= w_abs1;
            r_dvd_orig <= dIn0;
            r_neg_d    <= signedOp & dIn0[DIV_SIZE-1];
            r_neg_v    <= signedOp & dIn1[DIV_SIZE-1];
            r_rem      <= '0;
            r_count    <= '0;
            r_dbz      <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem   <= w_trial[DIV_SIZE] ? w_shift[DIV_SIZE-1:0] : w_trial[DIV_SIZE-1:0];
          r_dvd   <= {r_dvd[DIV_SIZE-2:0], ~w_trial[DIV_SIZE]};
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (r_dvs == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd_orig;
            r_dbz       <= 1'b1;
          end else if (w_ovf) begin
            r_quotient  <= r_dvd_orig;
            r_remainder <= '0;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign divByZero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider with a behavioural divide model
module tb_seq_divider;

  localparam int N   = 32;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signedOp;
  logic [N-1:0] dIn0;
  logic [N-1:0] dIn1;
  logic         busy;
  logic         done;
  logic         divByZero;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;

  int total = 0;
  int bad   = 0;

  seq_divider #(.DIV_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .signedOp(signedOp),
    .dIn0(dIn0), .dIn1(dIn1), .busy(busy), .done(done),
    .divByZero(divByZero), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic; 64-bit signed math gives truncating division
  // with a dividend-signed remainder, and wraps MIN/-1 back to MIN.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = N'(sa / sb);
      r  = N'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Drives one request and watches busy/done; lat counts edges from the
  // accepting edge to the edge at which done is sampled high.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       output int lat, output int busy_err, output int done_cnt);
    logic exp_busy;
    @(negedge clk);
    dIn0 = a; dIn1 = b; signedOp = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_err = 0; done_cnt = 0;
    for (int n = 0; n < N + 6; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      exp_busy = (n <= N);
      if (busy !== exp_busy) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) lat = n + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signedOp = 1'b0; dIn0 = '0; dIn1 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, divByZero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_state busy=%b done=%b dbz=%b q=%h r=%h want all zero",
               busy, done, divByZero, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, berr, dcnt;
    do_op(32'd100, 32'd7, 1'b0, lat, berr, dcnt);
    total++; if (lat !== LAT) begin bad++; $display("FAIL u100_7_latency got=%0d want=%0d", lat, LAT); end
    total++; if (berr !== 0) begin bad++; $display("FAIL u100_7_busy errors=%0d want=0", berr); end
    total++; if (dcnt !== 1) begin bad++; $display("FAIL u100_7_done_pulses got=%0d want=1", dcnt); end
    total++; if (quotient !== 32'd14 || remainder !== 32'd2 || divByZero !== 1'b0) begin
      bad++; $display("FAIL u100_7_result q=%0d r=%0d dbz=%b want 14 2 0", quotient, remainder, divByZero);
    end
  endtask

  task automatic test_signed();
    int lat, berr, dcnt;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, berr, dcnt);
    total++; if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL s_m7_2 q=%h r=%h want fffffffd ffffffff", quotient, remainder);
    end
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, lat, berr, dcnt);
    total++; if (quotient !== 32'h7FFF_FFFC || remainder !== 32'd1) begin
      bad++; $display("FAIL u_fff9_2 q=%h r=%h want 7ffffffc 00000001", quotient, remainder);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, berr, dcnt;
    for (int s = 0; s < 2; s++) begin
      do_op(32'd5, 32'd0, s[0], lat, berr, dcnt);
      total++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || divByZero !== 1'b1) begin
        bad++; $display("FAIL div0_s%0d q=%h r=%h dbz=%b want ffffffff 00000005 1", s, quotient, remainder, divByZero);
      end
      total++; if (lat !== LAT || berr !== 0) begin
        bad++; $display("FAIL div0_s%0d_timing lat=%0d busy_err=%0d want %0d 0", s, lat, berr, LAT);
      end
    end
    @(negedge clk);
    dIn0 = 32'd6; dIn1 = 32'd3; signedOp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (divByZero !== 1'b0) begin bad++; $display("FAIL div0_clear_on_start dbz=%b want 0", divByZero); end
    repeat (N + 4) @(posedge clk);
  endtask

  task automatic test_overflow();
    int lat, berr, dcnt;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, berr, dcnt);
    total++; if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || lat !== LAT) begin
      bad++; $display("FAIL s_overflow q=%h r=%h lat=%0d want 80000000 00000000 %0d", quotient, remainder, lat, LAT);
    end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, berr, dcnt);
    total++; if (quotient !== 32'd0 || remainder !== 32'h8000_0000) begin
      bad++; $display("FAIL u_min_max q=%h r=%h want 00000000 80000000", quotient, remainder);
    end
  endtask

  task automatic test_ignore_start();
    int lat, dcnt;
    @(negedge clk);
    dIn0 = 32'd1000; dIn1 = 32'd10; signedOp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; dcnt = 0;
    for (int n = 0; n < 2 * N + 8; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (done === 1'b1) begin dcnt++; if (lat < 0) lat = n + 1; end
      if (n == 4 || n == N + 1) begin dIn0 = 32'd9; dIn1 = 32'd3; start = 1'b1; end
      else start = 1'b0;
    end
    total++; if (dcnt !== 1 || lat !== LAT) begin
      bad++; $display("FAIL ignore_start done_pulses=%0d lat=%0d want 1 %0d", dcnt, lat, LAT);
    end
    total++; if (quotient !== 32'd100 || remainder !== 32'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL ignore_start_result q=%0d r=%0d busy=%b want 100 0 0", quotient, remainder, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, berr, dcnt;
    @(negedge clk);
    dIn0 = 32'd1000; dIn1 = 32'd10; signedOp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL mid_reset busy=%b done=%b q=%h r=%h want 0 0 0 0", busy, done, quotient, remainder);
    end
    do_op(32'd9, 32'd3, 1'b0, lat, berr, dcnt);
    total++; if (quotient !== 32'd3 || remainder !== 32'd0 || lat !== LAT || dcnt !== 1) begin
      bad++; $display("FAIL after_reset_9_3 q=%0d r=%0d lat=%0d pulses=%0d want 3 0 %0d 1", quotient, remainder, lat, dcnt, LAT);
    end
  endtask

  task automatic test_random();
    int lat, berr, dcnt;
    logic [N-1:0] a, b, eq, er;
    logic s, ez;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if (i % 6 == 5) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'd0 - $urandom_range(1, 255);
        default: b = $urandom & 32'h0000_0003;
      endcase
      s = $urandom_range(0, 1) == 1;
      model(a, b, s, eq, er, ez);
      do_op(a, b, s, lat, berr, dcnt);
      total++;
      if (quotient !== eq || remainder !== er || divByZero !== ez || lat !== LAT || berr !== 0 || dcnt !== 1) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h s=%b got q=%h r=%h z=%b lat=%0d berr=%0d dn=%0d want q=%h r=%h z=%b lat=%0d",
                 i, a, b, s, quotient, remainder, divByZero, lat, berr, dcnt, eq, er, ez, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_ignore_start();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
